// File: rtl/wb_mem_responder_pkg.sv
// Shared types and constants for the Wishbone memory responder.
package wb_mem_responder_pkg;

   localparam int unsigned WBR_AW_DEF = 32;
   localparam int unsigned WBR_DW_DEF = 32;
   localparam int unsigned WBR_WS_MAX = 15;

   typedef enum logic [2:0] {
      CTI_CLASSIC = 3'b000,
      CTI_INCR    = 3'b010,
      CTI_EOB     = 3'b111
   } cti_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK,
      BURST
   } wbr_state_t;

endpackage

// File: rtl/wb_mem_responder_if.sv
// Wishbone B3 bus bundle between an initiator and the memory responder.
interface wb_mem_responder_if
   import wb_mem_responder_pkg::*;
#(
   parameter int unsigned AW = WBR_AW_DEF,
   parameter int unsigned DW = WBR_DW_DEF
) ();

   logic              wb_cyc_i;
   logic              wb_stb_i;
   logic              wb_we_i;
   logic [AW-1:0]     wb_addr_i;
   logic [DW-1:0]     wb_dat_i;
   logic [DW/8-1:0]   wb_sel_i;
   logic [2:0]        wb_cti_i;
   logic              wb_ack_o;
   logic [DW-1:0]     wb_dat_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i,
      output wb_ack_o, wb_dat_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i,
      input  wb_ack_o, wb_dat_o
   );

endinterface

// File: rtl/wb_mem_bytewr.sv
// Byte-enable RAM with a registered read port; array contents are not reset.
module wb_mem_bytewr #(
   parameter int unsigned DW         = 32,
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  we_i,
   input  logic [DW/8-1:0]       be_i,
   input  logic [DEPTH_LOG2-1:0] waddr_i,
   input  logic [DW-1:0]         wdata_i,
   input  logic [DEPTH_LOG2-1:0] raddr_i,
   output logic [DW-1:0]         rdata_o
);

   logic [DW-1:0] mem_q [2**DEPTH_LOG2];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int unsigned k = 0; k < DW/8; k++) begin
            if (be_i[k]) begin
               mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone B3 slave backed by internal RAM: programmable wait states,
// classic and incrementing-burst cycles, byte-lane writes.
module wb_mem_responder
   import wb_mem_responder_pkg::*;
#(
   parameter int unsigned AW          = WBR_AW_DEF,
   parameter int unsigned DW          = WBR_DW_DEF,
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic               sys_clk,
   input  logic               RESETN,
   wb_mem_responder_if.slave  wb,
   output logic [15:0]        ack_cnt,
   output logic               busy
);

   localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   wbr_state_t            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic                  ack_q, ack_d;
   logic [15:0]           ack_cnt_q, ack_cnt_d;

   logic req;
   logic xfer;
   logic incr;
   logic unused_addr_bits;

   assign req  = wb.wb_cyc_i & wb.wb_stb_i;
   assign xfer = ack_q & req;
   assign incr = (wb.wb_cti_i == CTI_INCR);
   assign unused_addr_bits = ^{wb.wb_addr_i[AW-1:DEPTH_LOG2+2], wb.wb_addr_i[1:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               idx_d = wb.wb_addr_i[DEPTH_LOG2+1:2];
               if (WAIT_STATES == 0) begin
                  state_d = ACK;
               end else begin
                  cnt_d   = WS_LOAD;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!wb.wb_cyc_i) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACK: begin
            if (xfer && incr) begin
               state_d = BURST;
               idx_d   = idx_q + 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         BURST: begin
            if (!wb.wb_cyc_i) begin
               state_d = IDLE;
            end else if (xfer) begin
               if (incr) begin
                  idx_d = idx_q + 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      ack_d = (state_d == ACK) || (state_d == BURST);
   end

   always_comb begin
      ack_cnt_d = ack_cnt_q;
      if (xfer && (ack_cnt_q != '1)) begin
         ack_cnt_d = ack_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge sys_clk or negedge RESETN) begin
      if (!RESETN) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         ack_q     <= 1'b0;
         ack_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         ack_q     <= ack_d;
         ack_cnt_q <= ack_cnt_d;
      end
   end

   // Reading from idx_d keeps the data register one beat ahead, so burst reads need no bubble.
   wb_mem_bytewr #(
      .DW         (DW),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_mem (
      .clk_i   (sys_clk),
      .rst_ni  (RESETN),
      .we_i    (xfer & wb.wb_we_i),
      .be_i    (wb.wb_sel_i),
      .waddr_i (idx_q),
      .wdata_i (wb.wb_dat_i),
      .raddr_i (idx_d),
      .rdata_o (wb.wb_dat_o)
   );

   // Registered ack is masked by cyc&stb so burst stalls and aborts drop it at once.
   assign wb.wb_ack_o = ack_q & req;
   assign ack_cnt     = ack_cnt_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: doc/wb_mem_responder.md
Name: wb_mem_responder

Overview:
- Synthesizable Wishbone B3 slave responder: the target end of the Wishbone initiator interface the SDRAM-controller bench drives.
- Backed by a word-addressed internal memory, with a programmable number of wait states.
- Supports classic cycles and incrementing bursts (wb_cti_i), plus byte-lane writes.
- Used to self-check the bench's Wishbone driver and as a fast SDRAM stand-in for system-level sims.

Parameters:
- AW, 32: wb_addr_i width; byte address.
- DW, 32: data width; must be 32 in this revision.
- DEPTH_LOG2, 10: memory holds 2**DEPTH_LOG2 words.
- WAIT_STATES, 2: idle cycles inserted between request sampling and the first ack of a cycle; legal range 0..15.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_addr_i  in  AW  byte address.
- wb_dat_i  in  DW  write data.
- wb_sel_i  in  DW/8  byte enables.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst.
- wb_ack_o  out  1  transfer acknowledge (registered).
- wb_dat_o  out  DW  read data; valid while wb_ack_o=1 on a read.
- ack_cnt  out  16  count of completed transfers; saturates at 16'hFFFF.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, RESETN=0): wb_ack_o=0, wb_dat_o=0, ack_cnt=0, busy=0, state=IDLE, wait counter=0. Memory contents are not reset.
- Word index = wb_addr_i[DEPTH_LOG2+1:2]. Upper address bits alias and bits [1:0] are ignored.
- Transfer completes at a rising edge where wb_ack_o & wb_cyc_i & wb_stb_i = 1.
- Write: on completion, mem[idx] byte k <= wb_dat_i byte k for each wb_sel_i[k]=1.
- Read: wb_dat_o is registered from mem[idx] in the same cycle wb_ack_o is asserted. All lanes are driven regardless of sel.
- FSM states: IDLE, WAIT, ACK, BURST.
  - IDLE: cyc&stb sampled high -> latch idx. If WAIT_STATES=0 go to ACK, else load counter with WAIT_STATES-1 and go to WAIT. wb_ack_o is high in the cycle after ACK entry is decided.
  - WAIT: counter decrements each cycle. At 0 -> ACK. cyc=0 -> IDLE with no ack.
  - ACK: wb_ack_o=1 for exactly this cycle. On completion with cti=010 -> BURST, idx <= idx+1 (wraps mod depth). Otherwise -> IDLE; ack drops next cycle.
  - BURST: wb_ack_o=1 every cycle stb=1, with no wait states after the first beat. Each completion advances idx by 1 (wrap from 2**DEPTH_LOG2-1 to 0). stb=0 inside the burst -> ack=0 and idx holds. Completion with cti=111 or 000 -> IDLE. cyc=0 -> IDLE immediately, ack=0.
- Classic back-to-back: minimum one ack-low cycle between classic transfers, so the throughput is one transfer per WAIT_STATES+2 cycles.
- Read-burst data pipeline: wb_dat_o for beat n+1 is computed from idx+1 at the completion edge of beat n, so there is no bubble.
- cyc dropped while ack is high: no write occurs, and ack is low next cycle.
- we/sel/dat are sampled per beat. Changing we inside a burst is legal; each beat obeys its own we.
- ack_cnt increments by 1 per completion and holds at FFFF.
- RESETN asserted mid-cycle: all state is cleared immediately. A partially acked burst is abandoned and no further memory write occurs.

Decomposition:
- sdrctrl_package gains:
  - cti_t enum (CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111);
  - wbr_state_t enum (IDLE, WAIT, ACK, BURST);
  - constant WBR_WS_MAX=15.
- aw and dw defaults come from the package.
- Sub-module wb_mem_bytewr: DW-wide, 2**DEPTH_LOG2-deep byte-enable RAM with registered read port. The FSM, counters and address logic stay in the top.

Test Plan:
- Reset: RESETN=0 mid-WAIT with WAIT_STATES=2 -> wb_ack_o, busy and ack_cnt are 0 within the same cycle. After release, the first classic read ack arrives 3 cycles after stb.
- Classic write/read: write 32'hDEADBEEF to 0x0000_0010 with sel=4'hF, then write 32'h000000AA with sel=4'h1 to the same address. A classic read of 0x10 returns 32'hDEADBEAA, ack width is 1 cycle, and ack_cnt=3.
- Incrementing write burst of 4 beats at 0x0000_0FF8 (DEPTH_LOG2=10, cti 010,010,010,111) with data 1,2,3,4 -> words 1022, 1023, 0, 1 hold 1,2,3,4 (wrap). Acks are on 4 consecutive cycles after the wait states.
- Read burst with master stall: stb low for 2 cycles after beat 2 of 4 -> ack low exactly during the stall. Data sequence is unchanged and there is no repeated or skipped word.
- Abort: cyc dropped after beat 1 of a 4-beat write burst -> only word 0 is written, state returns to IDLE next cycle, and ack_cnt=1.
- Saturation: 65 540 classic acks -> ack_cnt=16'hFFFF and stays there.
